// File: rtl/ip_tx_arbiter.sv
// Round-robin transmit scheduler that shares one IPv4 header inserter between
// several payload sources. It latches the winner's header parameters and muxes its payload stream.
module ip_tx_arbiter #(
  parameter int NREQ          = 3,
  parameter int IFG           = 12,
  parameter int GRANT_TIMEOUT = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                tx_ready,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     req_is_icmp,
  input  logic [16*NREQ-1:0]  req_length,
  input  logic [32*NREQ-1:0]  req_dest_ip,
  input  logic [NREQ-1:0]     src_enable,
  input  logic [8*NREQ-1:0]   src_data,
  output logic [NREQ-1:0]     grant,
  output logic                ip_tx_enable,
  output logic [7:0]          ip_data,
  output logic                ip_is_icmp,
  output logic [15:0]         ip_length,
  output logic [31:0]         ip_destination_ip,
  input  logic                ip_active,
  output logic                timeout_pulse,
  output logic                length_error
);

  localparam int          IDX_W        = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [15:0] TIMEOUT_LAST = 16'(GRANT_TIMEOUT - 1);
  localparam logic [15:0] IFG_LOAD     = 16'(IFG);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_SEND,
    S_DRAIN,
    S_GAP
  } state_e;

  state_e             state_q, state_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic               is_icmp_q, is_icmp_d;
  logic [15:0]        length_q, length_d;
  logic [31:0]        dest_q, dest_d;
  logic [15:0]        byte_cnt_q, byte_cnt_d;
  logic [15:0]        timer_q, timer_d;
  logic               timeout_q, timeout_d;
  logic               lerr_q, lerr_d;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [NREQ-1:0]    win_onehot;
  logic               sel_icmp;
  logic [15:0]        sel_len;
  logic [31:0]        sel_dest;

  logic               g_en;
  logic               g_req;
  logic [7:0]         g_data;
  logic               data_phase;

  // Candidate position 'off' steps above 'base', wrapped into 0..NREQ-1.
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return IDX_W'(s);
  endfunction

  // Round-robin search starting just above the previous winner.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    win_found  = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    sel_icmp   = 1'b0;
    sel_len    = '0;
    sel_dest   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!win_found && req[wrap_idx(last_q, k)]) begin
        win_found = 1'b1;
        win_idx   = wrap_idx(last_q, k);
      end
    end
    if (win_found) win_onehot[win_idx] = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      if (win_onehot[i]) begin
        sel_icmp = sel_icmp | req_is_icmp[i];
        sel_len  = sel_len  | req_length[16*i +: 16];
        sel_dest = sel_dest | req_dest_ip[32*i +: 32];
      end
    end
  end

  // Only the granted source's enable, request and byte are visible downstream.
  always_comb begin
    g_en   = 1'b0;
    g_req  = 1'b0;
    g_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        g_en   = g_en  | src_enable[i];
        g_req  = g_req | req[i];
        g_data = g_data | src_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    is_icmp_d  = is_icmp_q;
    length_d   = length_q;
    dest_d     = dest_q;
    byte_cnt_d = byte_cnt_q;
    timer_d    = timer_q;
    timeout_d  = 1'b0;
    lerr_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (tx_ready && win_found) begin
          grant_d   = win_onehot;
          last_d    = win_idx;
          is_icmp_d = sel_icmp;
          length_d  = sel_len;
          dest_d    = sel_dest;
          timer_d   = '0;
          state_d   = S_GRANT;
        end
      end

      S_GRANT: begin
        if (g_en) begin
          byte_cnt_d = 16'd1;
          state_d    = S_SEND;
        end else if (!g_req) begin
          grant_d = '0;
          state_d = S_IDLE;
        end else if (timer_q == TIMEOUT_LAST) begin
          grant_d   = '0;
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end

      // A dropped request does not end the packet; only the enable does.
      S_SEND: begin
        if (g_en) begin
          if (byte_cnt_q != 16'hFFFF) byte_cnt_d = byte_cnt_q + 16'd1;
        end else begin
          grant_d = '0;
          lerr_d  = (byte_cnt_q != length_q);
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        if (!ip_active) begin
          if (IFG == 0) begin
            state_d = S_IDLE;
          end else begin
            timer_d = IFG_LOAD;
            state_d = S_GAP;
          end
        end
      end

      // The counter holds IFG on the first gap cycle; IDLE follows after IFG gap cycles.
      S_GAP: begin
        if (timer_q <= 16'd1) begin
          timer_d = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      last_q     <= IDX_W'(NREQ - 1);
      is_icmp_q  <= 1'b0;
      length_q   <= '0;
      dest_q     <= '0;
      byte_cnt_q <= '0;
      timer_q    <= '0;
      timeout_q  <= 1'b0;
      lerr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      is_icmp_q  <= is_icmp_d;
      length_q   <= length_d;
      dest_q     <= dest_d;
      byte_cnt_q <= byte_cnt_d;
      timer_q    <= timer_d;
      timeout_q  <= timeout_d;
      lerr_q     <= lerr_d;
    end
  end

  assign data_phase        = (state_q == S_GRANT) || (state_q == S_SEND);
  assign ip_tx_enable      = data_phase & g_en;
  assign ip_data           = data_phase ? g_data : 8'h00;
  assign grant             = grant_q;
  assign ip_is_icmp        = is_icmp_q;
  assign ip_length         = length_q;
  assign ip_destination_ip = dest_q;
  assign timeout_pulse     = timeout_q;
  assign length_error      = lerr_q;

endmodule

// File: tb/tb_ip_tx_arbiter.sv
// Directed bench for ip_tx_arbiter: grant order, gap timing, timeout, abort,
// masking, length error and mid-packet reset, checked against hand-computed values.
module tb_ip_tx_arbiter;

  localparam int NREQ = 3;

  logic               clock = 1'b0;
  logic               reset;
  logic               tx_ready;
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_is_icmp;
  logic [16*NREQ-1:0] req_length;
  logic [32*NREQ-1:0] req_dest_ip;
  logic [NREQ-1:0]    src_enable;
  logic [8*NREQ-1:0]  src_data;
  logic [NREQ-1:0]    grant;
  logic               ip_tx_enable;
  logic [7:0]         ip_data;
  logic               ip_is_icmp;
  logic [15:0]        ip_length;
  logic [31:0]        ip_destination_ip;
  logic               ip_active;
  logic               timeout_pulse;
  logic               length_error;

  int tests = 0;
  int fails = 0;

  ip_tx_arbiter #(.NREQ(3), .IFG(12), .GRANT_TIMEOUT(64)) dut (
    .clock             (clock),
    .reset             (reset),
    .tx_ready          (tx_ready),
    .req               (req),
    .req_is_icmp       (req_is_icmp),
    .req_length        (req_length),
    .req_dest_ip       (req_dest_ip),
    .src_enable        (src_enable),
    .src_data          (src_data),
    .grant             (grant),
    .ip_tx_enable      (ip_tx_enable),
    .ip_data           (ip_data),
    .ip_is_icmp        (ip_is_icmp),
    .ip_length         (ip_length),
    .ip_destination_ip (ip_destination_ip),
    .ip_active         (ip_active),
    .timeout_pulse     (timeout_pulse),
    .length_error      (length_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_params(input string tag, input logic icmp, input logic [15:0] len,
                              input logic [31:0] dest);
    check({tag, "_icmp"}, 32'(ip_is_icmp), 32'(icmp));
    check({tag, "_len"}, 32'(ip_length), 32'(len));
    check({tag, "_dest"}, ip_destination_ip, dest);
  endtask

  // Bounded wait for any grant, then compare it with the expected one-hot value.
  task automatic wait_grant(input string tag, input logic [NREQ-1:0] exp);
    int c;
    c = 0;
    while (grant == '0 && c < 200) begin
      tick();
      c++;
    end
    check(tag, 32'(grant), 32'(exp));
  endtask

  // Streams n bytes from the granted source, then lands on the first DRAIN cycle.
  task automatic send_packet(input string tag, input int src, input int n,
                             input logic [7:0] base, input logic exp_lerr);
    ip_active = 1'b1;
    for (int i = 0; i < n; i++) begin
      src_enable          = '0;
      src_enable[src]     = 1'b1;
      src_data            = '0;
      src_data[8*src +: 8] = 8'(base + 8'(i));
      #1;
      check({tag, "_en"}, 32'(ip_tx_enable), 32'h1);
      check({tag, "_data"}, 32'(ip_data), 32'(8'(base + 8'(i))));
      tick();
    end
    src_enable = '0;
    src_data   = '0;
    #1;
    check({tag, "_en_off"}, 32'(ip_tx_enable), 32'h0);
    tick();
    check({tag, "_lerr"}, 32'(length_error), 32'(exp_lerr));
    check({tag, "_drain_grant"}, 32'(grant), 32'h0);
  endtask

  initial begin
    reset       = 1'b0;
    tx_ready    = 1'b0;
    req         = '0;
    req_is_icmp = 3'b101;
    req_length  = {16'd4, 16'd10, 16'd4};
    req_dest_ip = {32'hAC100002, 32'hC0A80005, 32'h0A000001};
    src_enable  = '0;
    src_data    = '0;
    ip_active   = 1'b0;

    // Reset state
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_txen", 32'(ip_tx_enable), 32'h0);
    check("rst_data", 32'(ip_data), 32'h0);
    check_params("rst", 1'b0, 16'd0, 32'h0);
    check("rst_tmo", 32'(timeout_pulse), 32'h0);
    check("rst_lerr", 32'(length_error), 32'h0);

    // tx_ready low holds off a new grant
    req = 3'b010;
    tick();
    tick();
    check("txrdy_block", 32'(grant), 32'h0);

    // Single packet from source 1, one-cycle arbitration latency
    tx_ready = 1'b1;
    tick();
    check("single_grant", 32'(grant), 32'b010);
    check_params("single", 1'b0, 16'd10, 32'hC0A80005);
    req = '0;
    send_packet("single", 1, 10, 8'hA0, 1'b0);
    check("single_tmo", 32'(timeout_pulse), 32'h0);
    check_params("single_drain", 1'b0, 16'd10, 32'hC0A80005);
    req = 3'b001;
    tick();
    check("drain_hold", 32'(grant), 32'h0);
    ip_active = 1'b0;
    for (int c = 0; c < 13; c++) tick();
    check("gap_hold", 32'(grant), 32'h0);
    tick();
    check("gap_grant", 32'(grant), 32'b001);
    check_params("rr0", 1'b1, 16'd4, 32'h0A000001);

    // Round-robin with every source requesting
    req        = 3'b111;
    req_length = {16'd4, 16'd4, 16'd4};
    send_packet("rr0", 0, 4, 8'h10, 1'b0);
    ip_active = 1'b0;
    wait_grant("rr1_grant", 3'b010);
    check_params("rr1", 1'b0, 16'd4, 32'hC0A80005);
    send_packet("rr1", 1, 4, 8'h20, 1'b0);
    ip_active = 1'b0;
    wait_grant("rr2_grant", 3'b100);
    check_params("rr2", 1'b1, 16'd4, 32'hAC100002);
    send_packet("rr2", 2, 4, 8'h30, 1'b0);
    ip_active = 1'b0;
    wait_grant("rr3_grant", 3'b001);

    // Timeout: source 0 never raises enable; source 1 is next in line
    req                = 3'b011;
    req_length[31:16]  = 16'd8;
    for (int c = 0; c < 63; c++) tick();
    check("tmo_early", 32'(timeout_pulse), 32'h0);
    check("tmo_held", 32'(grant), 32'b001);
    tick();
    check("tmo_pulse", 32'(timeout_pulse), 32'h1);
    check("tmo_revoke", 32'(grant), 32'h0);
    tick();
    check("tmo_single", 32'(timeout_pulse), 32'h0);
    check("tmo_next", 32'(grant), 32'b010);
    check_params("lerr", 1'b0, 16'd8, 32'hC0A80005);

    // Length error: 7 bytes against a latched length of 8
    req = '0;
    send_packet("lerr", 1, 7, 8'h40, 1'b1);
    tick();
    check("lerr_single", 32'(length_error), 32'h0);
    check("lerr_len_stable", 32'(ip_length), 32'd8);
    req       = 3'b100;
    ip_active = 1'b0;
    wait_grant("abort_grant", 3'b100);
    check_params("abort", 1'b1, 16'd4, 32'hAC100002);

    // Masking and abort: source 0 toggles while source 2 holds the grant
    src_enable     = 3'b001;
    src_data[7:0]  = 8'hFF;
    #1;
    check("mask_en1", 32'(ip_tx_enable), 32'h0);
    check("mask_data", 32'(ip_data), 32'h0);
    tick();
    src_enable = '0;
    tick();
    src_enable = 3'b001;
    req        = '0;
    #1;
    check("mask_en2", 32'(ip_tx_enable), 32'h0);
    tick();
    check("abort_grant_clr", 32'(grant), 32'h0);
    check("abort_tmo", 32'(timeout_pulse), 32'h0);
    check("abort_lerr", 32'(length_error), 32'h0);
    src_enable = '0;
    src_data   = '0;
    req        = 3'b001;
    tick();
    check("abort_nogap", 32'(grant), 32'b001);

    // Reset in the middle of SEND
    req             = '0;
    src_enable      = 3'b001;
    src_data[7:0]   = 8'h55;
    tick();
    src_data[7:0]   = 8'h56;
    tick();
    reset = 1'b0;
    tick();
    check("mid_rst_grant", 32'(grant), 32'h0);
    check("mid_rst_txen", 32'(ip_tx_enable), 32'h0);
    check("mid_rst_data", 32'(ip_data), 32'h0);
    check_params("mid_rst", 1'b0, 16'd0, 32'h0);
    reset      = 1'b1;
    src_enable = '0;
    src_data   = '0;
    req        = 3'b111;
    tick();
    check("post_rst_grant", 32'(grant), 32'b001);

    // Zero-length request streamed for one cycle is flagged
    req                = 3'b010;
    req_length[31:16]  = 16'd0;
    send_packet("post_rst", 0, 4, 8'h60, 1'b0);
    ip_active = 1'b0;
    wait_grant("zero_grant", 3'b010);
    check("zero_len", 32'(ip_length), 32'd0);
    req = '0;
    send_packet("zero", 1, 1, 8'h70, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ip_tx_arbiter.md
# ip_tx_arbiter

Transmit-side scheduler that shares the single IPv4 header inserter (`ip_send`) between several payload sources, e.g. HPSDR UDP data, ICMP echo reply and DHCP. It arbitrates round-robin and latches the winner's header parameters (`is_icmp`, length, destination IP). It then muxes the winner's payload bytes and enable into the inserter and holds off the next grant until the inserter has purged its header shift register and an inter-packet gap has elapsed.

## Interface
- `NREQ`, 3: number of requesters; index 0 is served first after reset.
- `IFG`, 12: idle cycles after inserter `active` falls before the next arbitration; 0 means no gap.
- `GRANT_TIMEOUT`, 64: cycles a granted requester may take to raise its enable before the grant is revoked.
- `clock`  in  1  sole clock; all logic rises on `clock`.
- `reset`  in  1  synchronous, active-low (0 = reset), sampled on `clock`.
- `tx_ready`  in  1  downstream MAC can accept a new frame; sampled only in IDLE.
- `req`  in  NREQ  per-source request level; held until grant or withdrawn.
- `req_is_icmp`  in  NREQ  per-source protocol select.
- `req_length`  in  16*NREQ  per-source payload byte count; source i occupies [16i+15:16i].
- `req_dest_ip`  in  32*NREQ  per-source destination IP; source i occupies [32i+31:32i].
- `src_enable`  in  NREQ  per-source payload-valid; high for exactly `length` consecutive cycles.
- `src_data`  in  8*NREQ  per-source payload byte; source i occupies [8i+7:8i].
- `grant`  out  NREQ  one-hot grant, registered.
- `ip_tx_enable`  out  1  to inserter `tx_enable`.
- `ip_data`  out  8  to inserter `data_in`.
- `ip_is_icmp`  out  1  latched protocol select.
- `ip_length`  out  16  latched payload length.
- `ip_destination_ip`  out  32  latched destination IP.
- `ip_active`  in  1  inserter `active`.
- `timeout_pulse`  out  1  one-cycle flag: a grant was revoked.
- `length_error`  out  1  one-cycle flag: the streamed byte count did not equal the latched length.

## Operation
- States are IDLE, GRANT, SEND, DRAIN and GAP.
- **IDLE**
  - If `tx_ready`=1 and `req`≠0, select the first set `req` bit searching upward from `last+1` (mod NREQ).
  - On that cycle, register the one-hot `grant` and latch `ip_is_icmp`, `ip_length` and `ip_destination_ip` from the winner's slice.
  - Set `last` to the winner and go to GRANT.
- **GRANT**
  - `ip_tx_enable`/`ip_data` are combinationally muxed from the granted slice.
  - Granted `src_enable`=1 → SEND. The byte counter loads 1.
  - Granted `req`=0 while its enable is 0 → abort to IDLE. No gap, no flags.
  - `GRANT_TIMEOUT` cycles without enable → IDLE, pulse `timeout_pulse`.
- **SEND**
  - Mux stays active. The 16-bit byte counter increments on each enable cycle and saturates at FFFF.
  - When enable falls → DRAIN. If the count ≠ `ip_length`, pulse `length_error` on the first DRAIN cycle.
- **DRAIN**
  - `ip_tx_enable` is forced to 0 and `grant` clears.
  - Wait for `ip_active`=0, then go to GAP loaded with `IFG`, or to IDLE if `IFG`=0.
- **GAP**
  - Decrement the counter each cycle; go to IDLE when it reaches 0.
- **Masking:** enables and data from non-granted sources are ignored. `ip_tx_enable`=0 and `ip_data`=0 outside GRANT/SEND.
- **Stable parameters:** latched parameters hold from grant until the next grant, so they are constant through DRAIN.
- **Request changes:** a `req` that drops in SEND does not end the packet; only enable does.

## Timing
- **Reset values:** all outputs 0; `last`=NREQ-1; state IDLE. Reset mid-packet returns to IDLE on the next edge.
- **Arbitration latency:** 1 cycle from `req`/`tx_ready` sampled high in IDLE to `grant` high.
- **Data path:** enable and data reach the inserter combinationally, in the same cycle as `src_enable`; the block adds no pipeline stage.
- **Minimum turnaround:** enable falling edge to the next possible grant is: DRAIN cycles until `ip_active`=0, plus `IFG`, plus 1 IDLE cycle.
- **Boundaries:**
  - Simultaneous requests resolve strictly round-robin.
  - A withdrawn request is never granted.
  - `tx_ready`=0 blocks only new grants, never a packet already granted.
  - Zero-length requests are legal. They time out unless the source still raises enable for 1 cycle, which is then flagged as `length_error`.

## Test plan
- **Single packet:** reset, then `req[1]`=1, length=10, dest=C0A80005, 10 enable cycles → `grant`=010 one cycle later. `ip_tx_enable` is high for 10 cycles carrying source 1's bytes; no flags; the next grant is no earlier than `ip_active` fall + 12 cycles.
- **Round-robin:** all three `req` held high with 4-byte packets → grant order 001, 010, 100, 001. The parameters latched on each grant match that source's slices.
- **Timeout:** `req[0]` with no enable → `timeout_pulse` exactly 64 cycles after grant, then IDLE. The next grant goes to source 1 if it is requesting.
- **Abort and masking:** `req[2]` withdrawn 3 cycles into GRANT → IDLE with no gap and no flags. `src_enable[0]` toggling while source 2 is granted never appears on `ip_tx_enable`.
- **Length error:** length=8 with 7 enable cycles → one `length_error` pulse, and the packet still drains normally.
- **Reset mid-SEND:** `reset`=0 for 1 cycle mid-packet → next edge shows all outputs 0, state IDLE, and source 0 is served first afterwards.
